// File: rtl/can_field_seq_if.sv
// Bit-stream-processor sequencer bus: BTL/TCL-side controls in, BSP strobes and field status out.
// EXT_ID_EN adds the ide status signal.
interface can_field_seq_if;
  logic       clock;
  logic       start;
  logic       stuff_bit;
  logic       rx_bit;
  logic       abort;
  logic       zero;
  logic       halt;
  logic       ready_input;
  logic       rtr;
  logic [3:0] field;
  logic [3:0] byte_cnt;
  logic [3:0] dlc;
  logic       frame_done;
`ifdef EXT_ID_EN
  logic       ide;
`endif

  modport master (
`ifdef EXT_ID_EN
    input  ide,
`endif
    output clock, start, stuff_bit, rx_bit, abort,
    input  zero, halt, ready_input, rtr, field, byte_cnt, dlc, frame_done
  );

  modport slave (
`ifdef EXT_ID_EN
    output ide,
`endif
    input  clock, start, stuff_bit, rx_bit, abort,
    output zero, halt, ready_input, rtr, field, byte_cnt, dlc, frame_done
  );
endinterface

// File: rtl/can_field_seq.sv
// CAN frame-field sequencer: tracks field/bit position per bit-time enable, latches RTR/DLC, drives BSP strobes.
// Optional CAN 2.0B extended identifier handling is enabled by defining EXT_ID_EN.
module can_field_seq #(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3
) (
  input  logic          clk,
  input  logic          reset,
  can_field_seq_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ID      = 4'd1,
    S_RTR     = 4'd2,
    S_CTRL    = 4'd3,
    S_DLC     = 4'd4,
    S_DATA    = 4'd5,
    S_CRC     = 4'd6,
    S_CRC_DEL = 4'd7,
    S_ACK     = 4'd8,
    S_EOF     = 4'd9,
`ifdef EXT_ID_EN
    S_IFS     = 4'd10,
    S_EXT     = 4'd11
`else
    S_IFS     = 4'd10
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] bit_idx_q, bit_idx_d;
  logic       rtr_q, rtr_d;
  logic [3:0] dlc_q, dlc_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic       frame_done_q, frame_done_d;
`ifdef EXT_ID_EN
  logic       ide_q, ide_d;
`endif

  logic [4:0] field_len;
  logic       last_bit;
  logic       adv;
  logic [3:0] dlc_shift;
  logic [3:0] dlc_clamp;
  logic [3:0] byte_cnt_inc;

  assign adv          = bus.clock & ~bus.stuff_bit & ~bus.abort;
  assign dlc_shift    = {dlc_q[2:0], bus.rx_bit};
  assign dlc_clamp    = (dlc_shift > 4'd8) ? 4'd8 : dlc_shift;
  assign byte_cnt_inc = byte_cnt_q + 4'd1;

  always_comb begin
    field_len = 5'd1;
    case (state_q)
      S_ID:      field_len = 5'd11;
      S_RTR:     field_len = 5'd1;
      S_CTRL:    field_len = 5'd2;
      S_DLC:     field_len = 5'd4;
      S_DATA:    field_len = 5'd8;
      S_CRC:     field_len = 5'd15;
      S_CRC_DEL: field_len = 5'd1;
      S_ACK:     field_len = 5'd2;
      S_EOF:     field_len = 5'(EOF_BITS);
      S_IFS:     field_len = 5'(IFS_BITS);
`ifdef EXT_ID_EN
      S_EXT:     field_len = 5'd18;
`endif
      default:   field_len = 5'd1;
    endcase
  end

  assign last_bit = (bit_idx_q == field_len - 5'd1);

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    rtr_d        = rtr_q;
    dlc_d        = dlc_q;
    byte_cnt_d   = byte_cnt_q;
    frame_done_d = 1'b0;
`ifdef EXT_ID_EN
    ide_d        = ide_q;
`endif
    if (bus.abort) begin
      state_d   = S_IDLE;
      bit_idx_d = 5'd0;
    end else if (state_q == S_IDLE) begin
      // SOF itself is not counted; frame status clears as ID is entered.
      if (bus.clock && bus.start) begin
        state_d    = S_ID;
        bit_idx_d  = 5'd0;
        rtr_d      = 1'b0;
        dlc_d      = 4'd0;
        byte_cnt_d = 4'd0;
`ifdef EXT_ID_EN
        ide_d      = 1'b0;
`endif
      end
    end else if (adv) begin
      bit_idx_d = last_bit ? 5'd0 : bit_idx_q + 5'd1;
      case (state_q)
        S_ID: if (last_bit) state_d = S_RTR;
        S_RTR: begin
          rtr_d   = bus.rx_bit;
          state_d = S_CTRL;
        end
        S_CTRL: begin
`ifdef EXT_ID_EN
          // First CTRL bit of a base header is IDE; IDE=1 diverts into the 18-bit extension.
          if (bit_idx_q == 5'd0 && !ide_q) begin
            ide_d = bus.rx_bit;
            if (bus.rx_bit) begin
              state_d   = S_EXT;
              bit_idx_d = 5'd0;
            end
          end
`endif
          if (last_bit) state_d = S_DLC;
        end
`ifdef EXT_ID_EN
        S_EXT: if (last_bit) state_d = S_RTR;
`endif
        S_DLC: begin
          dlc_d = last_bit ? dlc_clamp : dlc_shift;
          if (last_bit) state_d = (rtr_q || dlc_clamp == 4'd0) ? S_CRC : S_DATA;
        end
        S_DATA: begin
          if (last_bit) begin
            byte_cnt_d = byte_cnt_inc;
            state_d    = (byte_cnt_inc == dlc_q) ? S_CRC : S_DATA;
          end
        end
        S_CRC:     if (last_bit) state_d = S_CRC_DEL;
        S_CRC_DEL: if (last_bit) state_d = S_ACK;
        S_ACK:     if (last_bit) state_d = S_EOF;
        S_EOF:     if (last_bit) state_d = S_IFS;
        S_IFS: begin
          if (last_bit) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          bit_idx_d = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_idx_q    <= 5'd0;
      rtr_q        <= 1'b0;
      dlc_q        <= 4'd0;
      byte_cnt_q   <= 4'd0;
      frame_done_q <= 1'b0;
`ifdef EXT_ID_EN
      ide_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      rtr_q        <= rtr_d;
      dlc_q        <= dlc_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_done_q <= frame_done_d;
`ifdef EXT_ID_EN
      ide_q        <= ide_d;
`endif
    end
  end

  assign bus.zero        = (state_q == S_ID || state_q == S_DATA || state_q == S_CRC) && bit_idx_q == 5'd0;
  assign bus.halt        = bus.stuff_bit || state_q == S_IDLE || state_q == S_CTRL || state_q == S_CRC_DEL
                           || state_q == S_ACK || state_q == S_EOF || state_q == S_IFS;
  assign bus.ready_input = ~bus.stuff_bit && ((state_q == S_DLC && bit_idx_q == 5'd3)
                                           || (state_q == S_DATA && bit_idx_q == 5'd7));
  assign bus.rtr         = rtr_q;
  assign bus.field       = state_q;
  assign bus.byte_cnt    = byte_cnt_q;
  assign bus.dlc         = dlc_q;
  assign bus.frame_done  = frame_done_q;
`ifdef EXT_ID_EN
  assign bus.ide         = ide_q;
`endif

endmodule

// File: tb/tb_can_field_seq.sv
// Scoreboard bench for can_field_seq: each frame is laid out as a per-bit expectation queue, then played bit by bit.
module tb_can_field_seq;
  localparam int EOF_N = 7;
  localparam int IFS_N = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  can_field_seq_if bus();
  can_field_seq #(.EOF_BITS(EOF_N), .IFS_BITS(IFS_N)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic       st;
    logic       rx;
    logic       sf;
    logic [3:0] f;
    logic       z;
    logic       h;
    logic       ri;
  } bit_t;

  bit_t sbq[$];
  int total = 0;
  int bad   = 0;

  function automatic logic halt_field(input logic [3:0] code);
    return code == 4'd0 || code == 4'd3 || code == 4'd7 || code == 4'd8 || code == 4'd9 || code == 4'd10;
  endfunction

  function automatic logic zero_field(input logic [3:0] code, input int i);
    return (code == 4'd1 || code == 4'd5 || code == 4'd6) && i == 0;
  endfunction

  task automatic push_bit(input logic st, input logic rx, input logic sf, input logic [3:0] f,
                          input logic z, input logic h, input logic ri);
    bit_t b;
    b.st = st; b.rx = rx; b.sf = sf; b.f = f; b.z = z; b.h = h; b.ri = ri;
    sbq.push_back(b);
  endtask

  task automatic add_field(input logic [3:0] code, input int n, input logic [31:0] val, input int stuff_at);
    for (int i = 0; i < n; i++) begin
      if (i == stuff_at) push_bit(1'b0, 1'b1, 1'b1, code, zero_field(code, i), 1'b1, 1'b0);
      push_bit(1'b0, val[n-1-i], 1'b0, code, zero_field(code, i), halt_field(code),
               (code == 4'd4 && i == 3) || (code == 4'd5 && i == 7));
    end
  endtask

  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input int stuff_id, input logic stuff_last);
    int nb;
    logic [31:0] byte_v;
    nb = rtr ? 0 : (dlc > 4'd8 ? 8 : int'(dlc));
    push_bit(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    add_field(4'd1, 11, 32'(id), stuff_id);
    add_field(4'd2, 1, 32'(rtr), -1);
    add_field(4'd3, 2, 32'd0, -1);
    add_field(4'd4, 4, 32'(dlc), -1);
    for (int b = 0; b < nb; b++) begin
      byte_v = 32'(data[63-8*b -: 8]);
      add_field(4'd5, 8, byte_v, (stuff_last && b == nb - 1) ? 7 : -1);
    end
    add_field(4'd6, 15, 32'h2B4D, -1);
    add_field(4'd7, 1, 32'd1, -1);
    add_field(4'd8, 2, 32'd1, -1);
    add_field(4'd9, EOF_N, 32'h7F, -1);
    add_field(4'd10, IFS_N, 32'h7, -1);
  endtask

  // Plays n queued bits: one enabled clk cycle per bit followed by one idle (clock=0) cycle.
  task automatic run_bits(input int n);
    bit_t b;
    for (int k = 0; k < n && sbq.size() > 0; k++) begin
      b = sbq.pop_front();
      @(negedge clk);
      bus.clock = 1'b1; bus.start = b.st; bus.rx_bit = b.rx; bus.stuff_bit = b.sf;
      #1;
      total += 4;
      if (bus.field !== b.f) begin bad++; $display("FAIL field bit%0d: got %0d want %0d", k, bus.field, b.f); end
      if (bus.zero !== b.z) begin bad++; $display("FAIL zero bit%0d: got %b want %b", k, bus.zero, b.z); end
      if (bus.halt !== b.h) begin bad++; $display("FAIL halt bit%0d: got %b want %b", k, bus.halt, b.h); end
      if (bus.ready_input !== b.ri) begin
        bad++; $display("FAIL ready_input bit%0d: got %b want %b", k, bus.ready_input, b.ri);
      end
      @(negedge clk);
      bus.clock = 1'b0; bus.start = 1'b0; bus.stuff_bit = 1'b0; bus.rx_bit = 1'b0;
    end
  endtask

  task automatic check_end(input string nm, input logic rtr, input logic [3:0] dlc, input logic [3:0] bc);
    #1;
    total += 5;
    if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL %s frame_done: got %b want 1", nm, bus.frame_done); end
    if (bus.field !== 4'd0) begin bad++; $display("FAIL %s end field: got %0d want 0", nm, bus.field); end
    if (bus.rtr !== rtr) begin bad++; $display("FAIL %s rtr: got %b want %b", nm, bus.rtr, rtr); end
    if (bus.dlc !== dlc) begin bad++; $display("FAIL %s dlc: got %0d want %0d", nm, bus.dlc, dlc); end
    if (bus.byte_cnt !== bc) begin bad++; $display("FAIL %s byte_cnt: got %0d want %0d", nm, bus.byte_cnt, bc); end
    @(negedge clk); #1;
    total++;
    if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL %s frame_done pulse width: got %b want 0", nm, bus.frame_done); end
  endtask

  task automatic test_reset();
    bus.clock = 1'b0; bus.start = 1'b0; bus.stuff_bit = 1'b0; bus.rx_bit = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total += 6;
    if (bus.field !== 4'd0) begin bad++; $display("FAIL reset field: got %0d want 0", bus.field); end
    if (bus.halt !== 1'b1) begin bad++; $display("FAIL reset halt: got %b want 1", bus.halt); end
    if (bus.zero !== 1'b0) begin bad++; $display("FAIL reset zero: got %b want 0", bus.zero); end
    if (bus.ready_input !== 1'b0) begin bad++; $display("FAIL reset ready_input: got %b want 0", bus.ready_input); end
    if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset frame_done: got %b want 0", bus.frame_done); end
    if (bus.byte_cnt !== 4'd0) begin bad++; $display("FAIL reset byte_cnt: got %0d want 0", bus.byte_cnt); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_data_frame();
    build_frame(11'h123, 1'b0, 4'd2, {8'hA5, 8'h3C, 48'h0}, -1, 1'b0);
    run_bits(1000);
    check_end("data", 1'b0, 4'd2, 4'd2);
  endtask

  task automatic test_remote_frame();
    build_frame(11'h5A1, 1'b1, 4'd5, 64'h0, -1, 1'b0);
    run_bits(1000);
    check_end("remote", 1'b1, 4'd5, 4'd0);
  endtask

  task automatic test_dlc_clamp();
    build_frame(11'h7F0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, -1, 1'b0);
    run_bits(1000);
    check_end("dlc15", 1'b0, 4'd8, 4'd8);
  endtask

  task automatic test_stuff();
    build_frame(11'h2AA, 1'b0, 4'd1, {8'hF1, 56'h0}, 3, 1'b1);
    run_bits(1000);
    check_end("stuff", 1'b0, 4'd1, 4'd1);
  endtask

  task automatic test_abort();
    build_frame(11'h011, 1'b0, 4'd3, {8'h11, 8'h22, 8'h33, 40'h0}, -1, 1'b0);
    run_bits(1 + 11 + 1 + 2 + 4 + 8 + 3);
    sbq.delete();
    @(negedge clk);
    bus.clock = 1'b1; bus.start = 1'b1; bus.abort = 1'b1; bus.rx_bit = 1'b1;
    @(negedge clk);
    bus.clock = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.rx_bit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total += 3;
      if (bus.field !== 4'd0) begin bad++; $display("FAIL abort field c%0d: got %0d want 0", c, bus.field); end
      if (bus.halt !== 1'b1) begin bad++; $display("FAIL abort halt c%0d: got %b want 1", c, bus.halt); end
      if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL abort frame_done c%0d: got %b want 0", c, bus.frame_done); end
      @(negedge clk);
    end
    build_frame(11'h444, 1'b0, 4'd1, {8'h5A, 56'h0}, -1, 1'b0);
    run_bits(1);
    #1;
    total++;
    if (bus.byte_cnt !== 4'd0) begin bad++; $display("FAIL restart byte_cnt: got %0d want 0", bus.byte_cnt); end
    run_bits(1000);
    check_end("restart", 1'b0, 4'd1, 4'd1);
  endtask

  task automatic test_reset_mid_crc();
    build_frame(11'h321, 1'b1, 4'd5, 64'h0, -1, 1'b0);
    run_bits(1 + 11 + 1 + 2 + 4 + 5);
    sbq.delete();
    #1;
    total += 2;
    if (bus.field !== 4'd6) begin bad++; $display("FAIL pre-reset field: got %0d want 6", bus.field); end
    if (bus.rtr !== 1'b1) begin bad++; $display("FAIL pre-reset rtr: got %b want 1", bus.rtr); end
    #1 reset = 1'b1;
    #1;
    total += 7;
    if (bus.field !== 4'd0) begin bad++; $display("FAIL midreset field: got %0d want 0", bus.field); end
    if (bus.rtr !== 1'b0) begin bad++; $display("FAIL midreset rtr: got %b want 0", bus.rtr); end
    if (bus.dlc !== 4'd0) begin bad++; $display("FAIL midreset dlc: got %0d want 0", bus.dlc); end
    if (bus.byte_cnt !== 4'd0) begin bad++; $display("FAIL midreset byte_cnt: got %0d want 0", bus.byte_cnt); end
    if (bus.halt !== 1'b1) begin bad++; $display("FAIL midreset halt: got %b want 1", bus.halt); end
    if (bus.zero !== 1'b0) begin bad++; $display("FAIL midreset zero: got %b want 0", bus.zero); end
    if (bus.ready_input !== 1'b0) begin bad++; $display("FAIL midreset ready_input: got %b want 0", bus.ready_input); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_data_frame();
    test_remote_frame();
    test_dlc_clamp();
    test_stuff();
    test_abort();
    test_reset_mid_crc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/can_field_seq.md
Name: can_field_seq

Overview:
Frame-field sequencer for the receive/transmit bit stream processor in the Basic CAN controller. It tracks position within a CAN 2.0A frame on every bit-time clock enable from BTL. It generates the bit-stream-processor control strobes (zero, halt, ready_input, rtr) and the field/byte status used by TCL and IML. It latches RTR and DLC from the received stream so it knows when DATA ends.

Parameters:
EOF_BITS, 7, length of End-of-Frame field in bits
IFS_BITS, 3, length of intermission in bits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset (HW and SW reset request)
clock  in  1  bit-time clock enable from BTL; all state advances only when high
start  in  1  SOF bit present on bus this bit time (from TCL)
stuff_bit  in  1  current bit is a stuff bit; do not count or load it
rx_bit  in  1  sampled bus bit (destuffed stream)
abort  in  1  error/arbitration-loss; return to IDLE
zero  out  1  first bit of a byte-aligned field (ID, each DATA byte, CRC)
halt  out  1  inhibit BSP load this bit
ready_input  out  1  last bit of DLC or of a DATA byte
rtr  out  1  latched RTR bit of current frame
field  out  4  current field code
byte_cnt  out  4  DATA bytes completed, 0..8
dlc  out  4  latched DLC, clamped to 8
frame_done  out  1  one-clk pulse when IFS completes

Behaviour:
- Reset: state IDLE, bit_idx=0, byte_cnt=0, dlc=0, rtr=0, frame_done=0. Hence zero=0, halt=1, ready_input=0, field=0.
- Field codes and lengths: IDLE=0; ID=1 (11 bits); RTR=2 (1); CTRL=3 (IDE+r0, 2); DLC=4 (4); DATA=5 (8 per byte); CRC=6 (15); CRC_DEL=7 (1); ACK=8 (slot+delim, 2); EOF=9 (EOF_BITS); IFS=10 (IFS_BITS).
- Advance condition: adv = clock & ~stuff_bit & ~abort. All registers hold when adv=0, except for the abort handling below.
- IDLE: when clock & start & ~abort, go to ID with bit_idx=0. The SOF bit itself is not counted.
- Counting: in each field, bit_idx increments on adv. On the last bit of the field (bit_idx == len-1), bit_idx clears and the state moves to the next field in the listed order.
- RTR state: on adv, rtr <= rx_bit.
- DLC state: on adv, shift rx_bit in MSB first. On exit, a value above 8 is stored as 8.
- After DLC: if rtr=1 or dlc=0, go to CRC and skip DATA.
- DATA: on each completed byte, byte_cnt increments. When byte_cnt reaches dlc, go to CRC; otherwise the next byte starts with bit_idx=0.
- IFS end: frame_done pulses for one clk and the state returns to IDLE. rtr, dlc and byte_cnt hold their values until the next start, then clear when ID is entered.
- Combinational outputs, decoded from registered state:
  - zero = (state in {ID, DATA, CRC}) & bit_idx==0.
  - halt = stuff_bit | state in {IDLE, CTRL, CRC_DEL, ACK, EOF, IFS}.
  - ready_input = ~stuff_bit & ((DLC & bit_idx==3) | (DATA & bit_idx==7)).
- abort: on any clk edge where abort=1, the state goes to IDLE and bit_idx to 0, regardless of clock. frame_done is not pulsed. abort wins over a simultaneous start.
- start while not in IDLE is ignored.
- stuff_bit on the last bit of a field: no transition occurs; the field continues until a non-stuff bit arrives.
- Latency: the field transition is visible in the clk cycle after the clock-enabled edge.

Optional Feature:
EXT_ID_EN: adds CAN 2.0B extended-frame handling.
- With the macro: the bit after the 11-bit ID is latched as SRR/RTR, and the next bit is latched as IDE.
  - If IDE=1, the sequence is field EXT=11 (18 bits), then RTR (the real RTR, which overwrites rtr), then CTRL reduced to 2 bits (r1, r0), then DLC.
  - zero is not asserted in EXT.
  - Output ide (1 bit, reset 0) is added.
- Without the macro: IDE is ignored, the frame is always handled as 11-bit, and neither the ide port nor the EXT code exists.

Test Plan:
- Data frame, no stuff: start, ID=0x123, RTR=0, DLC=2, data 0xA5 0x3C -> zero high at ID bit 0, byte 0 bit 0, byte 1 bit 0 and CRC bit 0; ready_input at DLC bit 3 and bit 7 of each byte; byte_cnt=2; frame_done after 11+1+2+4+16+15+1+2+7+3 = 62 enabled bits.
- Remote frame: RTR=1, DLC=5 -> rtr=1, dlc=5, byte_cnt=0, CRC entered directly after DLC.
- DLC=15 -> dlc=8, exactly 8 DATA bytes, then CRC.
- stuff_bit asserted on the 4th ID bit and on the last DATA bit -> halt=1 on those bits, bit_idx frozen, field lengths unchanged in counted bits.
- abort during DATA byte 1 with start high in the same cycle -> next clk field=0, halt=1, no frame_done; a later start begins a new frame with byte_cnt=0.
- reset asserted mid-CRC with clock=0 -> immediate field=0, rtr=0, dlc=0, outputs at reset values.
